// File: rtl/matrix_operand_loader.sv
`timescale 1ns/1ps
// Producer side of the matrix-multiply operand interface: packs a frame of operand
// words into the flat operand bus, fires a one-cycle start strobe, then freezes the operands.
module matrix_operand_loader #(
  parameter int MAT1_HEIGHT = 2,
  parameter int MAT1_WIDTH  = 2,
  parameter int MAT2_WIDTH  = 2,
  parameter int MAX_WORDS   = 18,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   clear,
  output logic [32*MAX_WORDS-1:0] matrix_inputs,
  output logic [31:0]            ready_signal,
  output logic                   busy,
  output logic                   frame_err,
  output logic [15:0]            frame_cnt
);

  // State table
  //   state   | meaning
  //   ST_LOAD | accepting operand words into slots
  //   ST_FIRE | single-cycle start strobe to the multiplier
  //   ST_HOLD | operands frozen while the multiplier computes
  localparam int NUM_WORDS = MAT1_HEIGHT*MAT1_WIDTH + MAT1_WIDTH*MAT2_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS-1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES-1);

  typedef enum logic [1:0] {ST_LOAD, ST_FIRE, ST_HOLD} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       slot_q [NUM_WORDS];

  // Gated by reset so the source never sees a handshake while the block is held in reset.
  assign in_ready = (state == ST_LOAD) && aresetn;

  always_comb begin
    matrix_inputs = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      matrix_inputs[k*32 +: 32] = slot_q[k];
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_LOAD;
      idx          <= '0;
      hold_cnt     <= '0;
      ready_signal <= '0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      frame_cnt    <= '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        slot_q[k] <= '0;
      end
    end else if (clear) begin
      // Slots and frame count survive an abort; only the frame in progress is dropped.
      state        <= ST_LOAD;
      idx          <= '0;
      hold_cnt     <= '0;
      ready_signal <= '0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            slot_q[idx] <= in_data;
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (in_last) begin
                state        <= ST_FIRE;
                ready_signal <= 32'd1;
                busy         <= 1'b1;
                frame_cnt    <= frame_cnt + 16'd1;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (in_last) begin
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_FIRE: begin
          ready_signal <= '0;
          hold_cnt     <= HOLD_LOAD;
          state        <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state <= ST_LOAD;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          state <= ST_LOAD;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
